// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//
// Collects a stream of samples into a D_WIDTH-slot frame and presents the
// completed frame in parallel to an FFT core through a valid/ready handshake.
// A second frame can fill while the previous one waits to be consumed. If a
// frame completes while the output is still occupied, the loader stalls in
// HOLD until the FFT takes the pending frame.
//
// Build option:
//   FFT_LOADER_BITREV_EN  when defined, the sample accepted at count k lands
//                         in slot bitrev(k). The FFT then receives its input
//                         in bit-reversed order. When undefined, slots fill
//                         in natural order.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_sample    streaming sample (S_WIDTH bits)
//   in_valid     in_sample is valid this cycle
//   in_ready     loader accepts a sample this cycle
//   frame_out    parallel frame; slot i at [S_WIDTH*i +: S_WIDTH]
//   frame_valid  frame_out holds a complete frame
//   frame_ready  FFT consumes frame_out this cycle
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting samples into the fill buffer
// HOLD  | fill buffer complete, waiting for the output slot to be freed
module fft_frame_loader #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6,
    parameter int S_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [S_WIDTH-1:0]           in_sample,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [S_WIDTH*D_WIDTH-1:0]   frame_out,
    output logic                         frame_valid,
    input  logic                         frame_ready
);

    localparam int FW = S_WIDTH * D_WIDTH;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [LOG_2_WIDTH-1:0] CNT_LAST = LOG_2_WIDTH'(D_WIDTH - 1);

    logic [0:0]             state_q, state_d;
    logic [LOG_2_WIDTH-1:0] cnt_q, cnt_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic                   frame_valid_q, frame_valid_d;

    logic                   accept;
    logic                   complete;
    logic                   slot_free;
    logic                   consume;
    logic [LOG_2_WIDTH-1:0] slot;

    function automatic logic [LOG_2_WIDTH-1:0] slot_of(input logic [LOG_2_WIDTH-1:0] k);
        logic [LOG_2_WIDTH-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
        for (int i = 0; i < LOG_2_WIDTH; i++) begin
            r[i] = k[LOG_2_WIDTH-1-i];
        end
`else
        r = k;
`endif
        return r;
    endfunction

    assign in_ready    = (state_q == ST_FILL);
    assign frame_out   = frame_q;
    assign frame_valid = frame_valid_q;

    assign accept    = in_valid && in_ready;
    assign complete  = accept && (cnt_q == CNT_LAST);
    assign consume   = frame_valid_q && frame_ready;
    assign slot_free = !frame_valid_q || frame_ready;
    assign slot      = slot_of(cnt_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fill_d        = fill_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;

        // Accepts only happen in FILL, so HOLD leaves the buffer frozen.
        for (int i = 0; i < D_WIDTH; i++) begin
            if (accept && (slot == LOG_2_WIDTH'(i))) begin
                fill_d[i*S_WIDTH +: S_WIDTH] = in_sample;
            end
        end

        if (consume) begin
            frame_valid_d = 1'b0;
        end

        if (state_q == ST_FILL) begin
            if (accept) begin
                cnt_d = complete ? '0 : cnt_q + LOG_2_WIDTH'(1);
            end
            if (complete) begin
                if (slot_free) begin
                    // fill_d already contains the last sample, so the frame
                    // leaves on this same edge with no bubble.
                    frame_d       = fill_d;
                    frame_valid_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
        end else begin
            if (consume) begin
                frame_d       = fill_q;
                frame_valid_d = 1'b1;
                state_d       = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            fill_q        <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_q        <= fill_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader. Completed frames are predicted as
// samples are sent and queued; each queued frame is checked against
// frame_out when the loader presents it. Works in both slot-order builds.
module tb_fft_frame_loader;

    localparam int D  = 64;
    localparam int L  = 6;
    localparam int S  = 16;
    localparam int FW = S * D;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [S-1:0]  in_sample = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic          frame_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] exp_fill = '0;
    int            tb_cnt = 0;

    fft_frame_loader #(.D_WIDTH(D), .LOG_2_WIDTH(L), .S_WIDTH(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    function automatic int map_slot(int k);
        int r;
`ifdef FFT_LOADER_BITREV_EN
        r = 0;
        for (int i = 0; i < L; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (L - 1 - i));
        end
`else
        r = k;
`endif
        return r;
    endfunction

    function automatic logic [S-1:0] slot_val(logic [FW-1:0] f, int i);
        return f[i*S +: S];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_frame(string tag);
        logic [FW-1:0] e;
        int bad;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s observed=frame expected=none queued", tag);
            return;
        end
        e = exp_q.pop_front();
        bad = 0;
        for (int i = D - 1; i >= 0; i--) begin
            if (slot_val(frame_out, i) !== slot_val(e, i)) bad = i;
        end
        assert (frame_out === e) else begin
            n_err++;
            $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, bad,
                   slot_val(frame_out, bad), slot_val(e, bad));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one sample for one cycle; caller guarantees in_ready is high.
    task automatic send(logic [S-1:0] v);
        in_valid  = 1'b1;
        in_sample = v;
        step();
        exp_fill[map_slot(tb_cnt)*S +: S] = v;
        tb_cnt++;
        if (tb_cnt == D) begin
            exp_q.push_back(exp_fill);
            tb_cnt = 0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic drop;
        logic early;
        int   k;
        int   cycles;

        // Reset: asynchronous, before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_frame_zero", 32'(frame_out === '0), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        chk("rst_in_ready_held", 32'(in_ready), 32'd1);
        #2 rst = 1'b0;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_frame_valid", 32'(frame_valid), 32'd0);

        // Back-to-back fill with the output free.
        frame_ready = 1'b1;
        drop = 1'b0;
        for (int i = 0; i < D - 1; i++) begin
            if (in_ready !== 1'b1) drop = 1'b1;
            send(S'(i));
        end
        chk("t1_fv_before_last", 32'(frame_valid), 32'd0);
        if (in_ready !== 1'b1) drop = 1'b1;
        send(S'(D - 1));
        chk("t1_fv_latency", 32'(frame_valid), 32'd1);
        chk("t1_ready_stable", 32'(drop), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_slot0", 32'(slot_val(frame_out, 0)), 32'(map_slot(0)));
        chk("t1_slot1", 32'(slot_val(frame_out, 1)), 32'(map_slot(1)));
        chk("t1_slot2", 32'(slot_val(frame_out, 2)), 32'(map_slot(2)));
        chk("t1_slot63", 32'(slot_val(frame_out, 63)), 32'(map_slot(63)));
        chk_frame("t1_frame");
        step();
        chk("t1_consumed", 32'(frame_valid), 32'd0);

        // Backpressure: two frames with frame_ready low.
        frame_ready = 1'b0;
        for (int i = 0; i < 2 * D; i++) send(S'(i));
        chk("t2_fv", 32'(frame_valid), 32'd1);
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        chk_frame("t2_frame_held");
        in_valid  = 1'b1;
        in_sample = 16'hbeef;
        step();
        step();
        in_valid = 1'b0;
        chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
        chk("t2_hold_fv", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("t2_release_fv", 32'(frame_valid), 32'd1);
        chk("t2_release_in_ready", 32'(in_ready), 32'd1);
        chk("t2_slot0", 32'(slot_val(frame_out, 0)), 32'(64 + map_slot(0)));
        chk_frame("t2_frame_second");
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("t2_consumed", 32'(frame_valid), 32'd0);

        // Last sample of frame B lands on the edge that consumes frame A.
        for (int i = 0; i < D; i++) send(S'(200 + i));
        chk("t3_fv_a", 32'(frame_valid), 32'd1);
        for (int i = 0; i < D - 1; i++) send(S'(300 + i));
        chk("t3_fv_before", 32'(frame_valid), 32'd1);
        chk_frame("t3_frame_a");
        frame_ready = 1'b1;
        send(S'(300 + D - 1));
        frame_ready = 1'b0;
        chk("t3_fv_no_gap", 32'(frame_valid), 32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        chk_frame("t3_frame_b");
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("t3_consumed", 32'(frame_valid), 32'd0);

        // Asynchronous reset mid-fill while a frame is pending.
        for (int i = 0; i < D; i++) send(S'(500 + i));
        chk_frame("t4_pending");
        for (int i = 0; i < 10; i++) send(S'(600 + i));
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_fv", 32'(frame_valid), 32'd0);
        chk("t4_rst_frame_zero", 32'(frame_out === '0), 32'd1);
        chk("t4_rst_in_ready", 32'(in_ready), 32'd1);
        exp_fill = '0;
        tb_cnt   = 0;
        #2 rst = 1'b0;
        step();
        chk("t4_rel_in_ready", 32'(in_ready), 32'd1);
        chk("t4_rel_fv", 32'(frame_valid), 32'd0);
        frame_ready = 1'b1;
        for (int i = 0; i < D; i++) send(S'(100 + i));
        chk("t4_fv", 32'(frame_valid), 32'd1);
        chk("t4_slot0", 32'(slot_val(frame_out, 0)), 32'd100);
        chk("t4_slot63", 32'(slot_val(frame_out, 63)), 32'd163);
        chk_frame("t4_frame");
        step();
        chk("t4_consumed", 32'(frame_valid), 32'd0);

        // Sparse input at roughly 30% duty; idle cycles carry junk samples.
        k      = 0;
        cycles = 0;
        early  = 1'b0;
        while (k < D && cycles < 3000) begin
            if ($urandom_range(99) < 30) begin
                send(S'(k));
                k++;
            end else begin
                in_valid  = 1'b0;
                in_sample = S'($urandom);
                step();
            end
            cycles++;
            if (k < D && frame_valid !== 1'b0) early = 1'b1;
        end
        chk("t5_budget", 32'(k), 32'(D));
        chk("t5_no_early_fv", 32'(early), 32'd0);
        chk("t5_fv_latency", 32'(frame_valid), 32'd1);
        chk_frame("t5_frame");
        step();
        chk("t5_consumed", 32'(frame_valid), 32'd0);
        frame_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64, meaning the number of samples per FFT frame.
REQ-002 SHALL have parameter LOG_2_WIDTH, default 6, meaning log2(D_WIDTH), which is the sample-counter width.
REQ-003 SHALL have parameter S_WIDTH, default 16, meaning the bits per sample.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the asynchronous, active-high reset.
REQ-006 SHALL have port in_sample  input  S_WIDTH  meaning the streaming sample.
REQ-007 SHALL have port in_valid  input  1  meaning in_sample is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  meaning the loader accepts a sample this cycle.
REQ-009 SHALL have port frame_out  output  S_WIDTH*D_WIDTH  meaning the parallel frame driven to the FFT input_sig; slot i occupies bits [S_WIDTH*i+S_WIDTH-1 -: S_WIDTH].
REQ-010 SHALL have port frame_valid  output  1  meaning frame_out holds a complete frame.
REQ-011 SHALL have port frame_ready  input  1  meaning the FFT consumes frame_out this cycle.

Function
REQ-012 SHALL accept a sample when in_valid && in_ready, writing it into an internal fill buffer at slot cnt and then incrementing cnt.
REQ-013 SHALL implement the two-state FSM FILL/HOLD, with in_ready = (state==FILL) decoded combinationally from the registered state.
REQ-014 SHALL treat the frame as complete on an accept with cnt==D_WIDTH-1, wrapping cnt to 0 on that accept.
REQ-015 SHALL, on completion when the output slot is free (!frame_valid || frame_ready), load the completed frame, including the last sample, into frame_out at that edge, set frame_valid=1, and remain in FILL with no bubble.
REQ-016 SHALL, on completion when the output slot is occupied (frame_valid && !frame_ready), enter HOLD with the fill buffer frozen.
REQ-017 SHALL, in HOLD, on frame_valid && frame_ready, copy the fill buffer to frame_out, keep frame_valid=1, and return to FILL.
REQ-018 SHALL clear frame_valid on frame_valid && frame_ready when no new frame is loaded that edge.
REQ-019 SHALL hold frame_out stable while frame_valid=1 && frame_ready=0.
REQ-020 SHALL make frame latency 1 cycle: frame_valid is visible in the cycle after the edge that accepted the last sample, when the slot is free.
REQ-021 SHALL ignore frame_ready while frame_valid=0, and ignore in_sample while in_valid=0; gaps in in_valid do not disturb cnt.
REQ-022 SHALL pass samples unmodified, with no arithmetic, sign or width conversion.

Reset
REQ-023 SHALL, on rst asserted and independent of clk, set frame_valid=0, frame_out=0, cnt=0, fill buffer=0 and state=FILL.
REQ-024 SHALL drive in_ready=1 while rst is asserted and in the first cycle after release.
REQ-025 SHALL discard any partial frame on reset mid-fill; the first sample after release goes to slot 0 (or its mapped slot per REQ-026).

Configuration
REQ-026 SHALL, with macro FFT_LOADER_BITREV_EN defined, write the sample accepted at count k into slot bitrev_LOG_2_WIDTH(k), giving bit-reversed input order for the FFT.
REQ-027 SHALL, without FFT_LOADER_BITREV_EN, write the sample at count k into slot k, in natural order.
REQ-028 SHALL keep handshake, latency and reset behaviour identical in both builds.

Verification
REQ-029 SHALL cover natural order: frame_ready=1, feed 0..63 back-to-back -> frame_valid=1 one cycle after the 64th accept, slot i == i, in_ready never deasserts.
REQ-030 SHALL cover bit-reverse order: FFT_LOADER_BITREV_EN defined, feed 0..63 -> slot 1 == 32, slot 2 == 16, slot 63 == 63, slot 0 == 0.
REQ-031 SHALL cover backpressure: frame_ready=0, feed 0..127 -> frame_out holds 0..63, in_ready=0 after the 128th accept; pulse frame_ready one cycle -> next cycle frame_out slot i == 64+i, frame_valid=1, in_ready=1.
REQ-032 SHALL cover the simultaneous event: the last sample of frame 2 is accepted on the same edge that frame_ready consumes frame 1 -> frame_valid stays 1 with no low cycle, and frame_out switches to frame 2.
REQ-033 SHALL cover reset mid-fill: accept 10 samples, assert rst asynchronously between edges -> frame_valid=0 immediately; then feed 100..163 -> slot 0 == 100 and slot 63 == 163.
REQ-034 SHALL cover sparse input: in_valid toggled randomly at a 30% duty, feed 0..63 -> the frame equals the back-to-back case, and frame_valid rises one cycle after the 64th accept.
